// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the fetch-stage state encoding,
// reused by control and the decode stage.
package cpu_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 16;

    typedef enum logic {
        IF_IDLE = 1'b0,
        IF_WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read bus between the fetch stage (master) and memory (slave).
interface instruction_fetch_if #(
    parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH
) ();

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_data;

    modport master (
        output mem_addr,
        output mem_rd,
        input  mem_ready,
        input  mem_data
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        output mem_ready,
        output mem_data
    );

endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: reads one word at the current PC, latches it into the
// instruction register and pulses pc_inc so program_counter advances.
module instruction_fetch #(
    parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
    parameter int TIMEOUT    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  fetch_req,
    input  logic                  flush,
    instruction_fetch_if.master   mem,
    output logic [DATA_WIDTH-1:0] ir,
    output logic                  ir_valid,
    output logic                  pc_inc,
    output logic                  busy,
    output logic                  fault
);

    import cpu_pkg::*;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_rd_q, mem_rd_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic                  ir_valid_q, ir_valid_d;
    logic                  pc_inc_q, pc_inc_d;
    logic                  fault_q, fault_d;
    logic [7:0]            wait_cnt_q, wait_cnt_d;

    // Next-state logic: accept in IDLE, then flush > data > timeout > count in WAIT.
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = mem_rd_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        pc_inc_d   = 1'b0;
        fault_d    = fault_q;
        wait_cnt_d = wait_cnt_q;

        if (state_q == IF_IDLE) begin
            // While pc_inc is still high the PC has not advanced yet, so a
            // request this cycle would refetch the old address.
            if (fetch_req && !pc_inc_q) begin
                mem_addr_d = pc;
                mem_rd_d   = 1'b1;
                ir_valid_d = 1'b0;
                fault_d    = 1'b0;
                wait_cnt_d = '0;
                state_d    = IF_WAIT;
            end
        end else begin
            if (flush) begin
                mem_rd_d = 1'b0;
                state_d  = IF_IDLE;
            end else if (mem.mem_ready) begin
                ir_d       = mem.mem_data;
                ir_valid_d = 1'b1;
                pc_inc_d   = 1'b1;
                mem_rd_d   = 1'b0;
                state_d    = IF_IDLE;
            end else if (wait_cnt_q == LAST_WAIT) begin
                fault_d  = 1'b1;
                mem_rd_d = 1'b0;
                state_d  = IF_IDLE;
            end else begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IF_IDLE;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            pc_inc_q   <= 1'b0;
            fault_q    <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            pc_inc_q   <= pc_inc_d;
            fault_q    <= fault_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign mem.mem_addr = mem_addr_q;
    assign mem.mem_rd   = mem_rd_q;
    assign ir           = ir_q;
    assign ir_valid     = ir_valid_q;
    assign pc_inc       = pc_inc_q;
    assign busy         = (state_q == IF_WAIT);
    assign fault        = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a small program_counter model
// and an optional zero-wait memory responder.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic        fetch_req;
    logic        flush;
    logic [15:0] ir;
    logic        ir_valid;
    logic        pc_inc;
    logic        busy;
    logic        fault;

    logic        pc_load;
    logic [15:0] pc_load_val;
    logic        mem_auto;
    logic        ready_drv;
    logic [15:0] data_drv;

    int checks   = 0;
    int failures = 0;
    int pulses;

    instruction_fetch_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) mem_bus ();

    instruction_fetch #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .TIMEOUT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .fetch_req (fetch_req),
        .flush     (flush),
        .mem       (mem_bus.master),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .pc_inc    (pc_inc),
        .busy      (busy),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    // Memory: either answers immediately with data=addr, or follows the bench drivers.
    assign mem_bus.mem_ready = mem_auto ? mem_bus.mem_rd : ready_drv;
    assign mem_bus.mem_data  = mem_auto ? mem_bus.mem_addr : data_drv;

    // program_counter model: load from bench, else increment on pc_inc.
    always @(posedge clk) begin
        if (pc_load)     pc <= pc_load_val;
        else if (pc_inc) pc <= pc + 16'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; fetch_req = 1'b1; flush = 1'b0;
        pc_load = 1'b1; pc_load_val = 16'h0000;
        mem_auto = 1'b0; ready_drv = 1'b1; data_drv = 16'hFFFF;

        // Reset held with request and ready active.
        tick(); tick();
        check("rst_mem_addr", 32'(mem_bus.mem_addr), 32'h0);
        check("rst_mem_rd", 32'(mem_bus.mem_rd), 32'h0);
        check("rst_ir", 32'(ir), 32'h0);
        check("rst_ir_valid", 32'(ir_valid), 32'h0);
        check("rst_pc_inc", 32'(pc_inc), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);

        rst = 1'b1; fetch_req = 1'b0; ready_drv = 1'b0; pc_load_val = 16'h0004;
        tick();
        pc_load = 1'b0;
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_mem_rd", 32'(mem_bus.mem_rd), 32'h0);

        // Basic fetch at 0004.
        fetch_req = 1'b1;
        tick();
        check("basic_addr", 32'(mem_bus.mem_addr), 32'h0004);
        check("basic_rd", 32'(mem_bus.mem_rd), 32'h1);
        check("basic_busy", 32'(busy), 32'h1);
        check("basic_valid0", 32'(ir_valid), 32'h0);
        fetch_req = 1'b0; ready_drv = 1'b1; data_drv = 16'hA5C3;
        tick();
        check("basic_ir", 32'(ir), 32'hA5C3);
        check("basic_valid", 32'(ir_valid), 32'h1);
        check("basic_pc_inc", 32'(pc_inc), 32'h1);
        check("basic_rd_low", 32'(mem_bus.mem_rd), 32'h0);
        check("basic_busy_low", 32'(busy), 32'h0);
        ready_drv = 1'b0;
        tick();
        check("basic_pc_inc_end", 32'(pc_inc), 32'h0);
        check("basic_pc", 32'(pc), 32'h0005);

        // Back-to-back fetches from 0000 with zero-wait memory.
        pc_load = 1'b1; pc_load_val = 16'h0000;
        tick();
        pc_load = 1'b0; fetch_req = 1'b1; mem_auto = 1'b1;
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (pc_inc) pulses++;
            if (i % 3 == 0) begin
                check("b2b_addr", 32'(mem_bus.mem_addr), 32'(i / 3));
                check("b2b_rd", 32'(mem_bus.mem_rd), 32'h1);
            end
        end
        fetch_req = 1'b0; mem_auto = 1'b0;
        check("b2b_pulses", 32'(pulses), 32'd3);
        check("b2b_ir", 32'(ir), 32'h0002);
        check("b2b_pc", 32'(pc), 32'h0003);
        tick();
        check("b2b_idle", 32'(busy), 32'h0);

        // Five-cycle wait.
        fetch_req = 1'b1;
        tick();
        check("ws_addr", 32'(mem_bus.mem_addr), 32'h0003);
        fetch_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ws_rd_held", 32'(mem_bus.mem_rd), 32'h1);
            check("ws_busy", 32'(busy), 32'h1);
            check("ws_no_inc", 32'(pc_inc), 32'h0);
        end
        ready_drv = 1'b1; data_drv = 16'h1234;
        tick();
        check("ws_ir", 32'(ir), 32'h1234);
        check("ws_pc_inc", 32'(pc_inc), 32'h1);
        check("ws_fault", 32'(fault), 32'h0);
        check("ws_rd_low", 32'(mem_bus.mem_rd), 32'h0);
        ready_drv = 1'b0;
        tick();
        check("ws_pc", 32'(pc), 32'h0004);

        // Timeout after 8 WAIT cycles.
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("to_busy", 32'(busy), 32'h1);
            check("to_fault0", 32'(fault), 32'h0);
            check("to_no_inc", 32'(pc_inc), 32'h0);
        end
        tick();
        check("to_fault", 32'(fault), 32'h1);
        check("to_rd_low", 32'(mem_bus.mem_rd), 32'h0);
        check("to_busy_low", 32'(busy), 32'h0);
        check("to_valid", 32'(ir_valid), 32'h0);
        check("to_pc_inc", 32'(pc_inc), 32'h0);
        tick();
        check("to_fault_sticky", 32'(fault), 32'h1);
        check("to_pc", 32'(pc), 32'h0004);

        // New request clears fault; data on the last WAIT cycle beats timeout.
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        check("clr_fault", 32'(fault), 32'h0);
        check("clr_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 7; i++) tick();
        ready_drv = 1'b1; data_drv = 16'hBEEF;
        tick();
        check("edge_ir", 32'(ir), 32'hBEEF);
        check("edge_valid", 32'(ir_valid), 32'h1);
        check("edge_pc_inc", 32'(pc_inc), 32'h1);
        check("edge_fault", 32'(fault), 32'h0);
        ready_drv = 1'b0;
        tick();
        check("edge_pc", 32'(pc), 32'h0005);

        // Flush wins over simultaneous mem_ready.
        fetch_req = 1'b1;
        tick();
        check("fl_addr", 32'(mem_bus.mem_addr), 32'h0005);
        check("fl_valid0", 32'(ir_valid), 32'h0);
        fetch_req = 1'b0; flush = 1'b1; ready_drv = 1'b1; data_drv = 16'h1111;
        tick();
        check("fl_busy", 32'(busy), 32'h0);
        check("fl_rd", 32'(mem_bus.mem_rd), 32'h0);
        check("fl_ir", 32'(ir), 32'hBEEF);
        check("fl_valid", 32'(ir_valid), 32'h0);
        check("fl_pc_inc", 32'(pc_inc), 32'h0);
        ready_drv = 1'b0;
        tick();
        check("fl_pc", 32'(pc), 32'h0005);
        check("fl_idle_busy", 32'(busy), 32'h0);

        // Flush in IDLE does not block an accept; then reset mid-WAIT.
        fetch_req = 1'b1; flush = 1'b1;
        tick();
        check("fli_busy", 32'(busy), 32'h1);
        fetch_req = 1'b0; flush = 1'b0; ready_drv = 1'b1; data_drv = 16'h2222; rst = 1'b0;
        tick();
        check("rw_busy", 32'(busy), 32'h0);
        check("rw_rd", 32'(mem_bus.mem_rd), 32'h0);
        check("rw_addr", 32'(mem_bus.mem_addr), 32'h0);
        check("rw_ir", 32'(ir), 32'h0);
        check("rw_valid", 32'(ir_valid), 32'h0);
        check("rw_pc_inc", 32'(pc_inc), 32'h0);
        rst = 1'b1; ready_drv = 1'b0;
        tick();
        check("rw_pc", 32'(pc), 32'h0005);
        check("rw_idle", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly downstream of program_counter: consumes the PC value, issues a single-word read to instruction memory, and latches the returned word into the instruction register.
- Drives program_counter's pc_enable with a one-cycle increment pulse after each successful fetch (program_counter select held 0 by control for sequential flow).
- Sits between program_counter and the decode/control unit; control requests fetches and may flush an in-flight fetch on a branch.

Parameters:
- DATA_WIDTH, 16, instruction word width.
- ADDR_WIDTH, 16, PC / memory address width.
- TIMEOUT, 8, maximum WAIT cycles without mem_ready before fault; legal range 2..255.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-low reset (rst=0 resets on the clock edge).
- pc  input  ADDR_WIDTH  current program_counter output.
- fetch_req  input  1  control requests one instruction fetch.
- flush  input  1  abandon any in-flight fetch (branch taken).
- mem_addr  output  ADDR_WIDTH  registered read address.
- mem_rd  output  1  read strobe, held high until accepted, flushed or timed out.
- mem_ready  input  1  memory returns valid mem_data this cycle.
- mem_data  input  DATA_WIDTH  instruction word from memory.
- ir  output  DATA_WIDTH  instruction register.
- ir_valid  output  1  ir holds a word from the most recent completed fetch.
- pc_inc  output  1  one-cycle pulse to program_counter pc_enable.
- busy  output  1  high while in WAIT.
- fault  output  1  sticky fetch-timeout flag.

Behaviour:
- Reset (rst=0 at edge): state IDLE; mem_addr=0, mem_rd=0, ir=0, ir_valid=0, pc_inc=0, busy=0, fault=0, wait_cnt=0. Reset mid-fetch aborts immediately: no ir update, no pc_inc.
- States: IDLE, WAIT. busy = (state==WAIT). All outputs registered.
- IDLE: fetch_req=1 and pc_inc=0 at edge -> mem_addr<=pc, mem_rd<=1, ir_valid<=0, fault<=0, wait_cnt<=0, state<=WAIT. fetch_req while pc_inc=1 is ignored for that cycle (PC has not yet incremented; prevents refetching the stale address). flush in IDLE has no effect.
- WAIT, priority order at each edge:
  1. flush=1 -> mem_rd<=0, state<=IDLE; ir, ir_valid unchanged (ir_valid stays 0); no pc_inc. flush wins over a simultaneous mem_ready.
  2. mem_ready=1 -> ir<=mem_data, ir_valid<=1, pc_inc<=1, mem_rd<=0, state<=IDLE.
  3. wait_cnt==TIMEOUT-1 -> fault<=1, mem_rd<=0, state<=IDLE; no pc_inc, ir_valid stays 0.
  4. else wait_cnt<=wait_cnt+1.
- pc_inc is high for exactly one cycle after the accepting edge, then 0. program_counter increments on the following edge.
- Latency: fetch_req sampled at edge N; mem_ready sampled at N+1 at earliest -> ir/ir_valid valid after N+1; pc_inc high N+1..N+2; earliest next accept at N+3 with the incremented pc.
- mem_addr holds its last value outside WAIT; mem_data is ignored outside WAIT.
- fault is sticky until the next accepted fetch_req or reset. wait_cnt is 8 bits and never wraps, because TIMEOUT<=255.

Decomposition:
- Shared package cpu_pkg: DATA_WIDTH/ADDR_WIDTH constants (16) and fetch state encoding (IF_IDLE=1'b0, IF_WAIT=1'b1), reused by control and the future decode stage.
- No sub-module needed. The timeout counter stays inline in the FSM always block.

Test Plan:
- Reset: rst=0 for 2 cycles with fetch_req=1, mem_ready=1 -> all outputs 0, state IDLE; after rst=1, nothing happens until fetch_req is sampled in IDLE.
- Basic fetch: pc=16'h0004, fetch_req 1 cycle, mem_ready=1 with mem_data=16'hA5C3 one cycle later -> mem_addr=0004, mem_rd high 1 cycle, ir=A5C3, ir_valid=1, pc_inc 1-cycle pulse; connected program_counter reads 0005.
- Back-to-back: fetch_req held high, memory answering 0-wait with data=addr -> fetches at 0000,0001,0002 every 3 cycles; no address fetched twice; exactly 3 pc_inc pulses.
- Wait states: mem_ready delayed 5 cycles with TIMEOUT=8 -> mem_rd held 5 cycles, busy=1 throughout, one pc_inc, fault=0.
- Timeout: mem_ready never asserted -> after 8 WAIT cycles fault=1, mem_rd=0, pc_inc never pulses, ir_valid=0; next fetch_req clears fault.
- Flush with simultaneous mem_ready=1 in WAIT -> ir unchanged, ir_valid=0, no pc_inc, IDLE next cycle; rst=0 mid-WAIT -> same abort plus all outputs zero.
